// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles, branch flushes and the halt drain sequence.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        ifid_uses_rt_i,
  input  logic        idex_DRen_i,
  input  logic [4:0]  idex_Rt_i,
  input  logic        branch_taken_i,
  input  logic        ihit_i,
  input  logic        dmem_req_i,
  input  logic        dhit_i,
  input  logic        exmem_halt_i,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        idex_noop,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    MEMWAIT = 3'd1,
    FLUSH   = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       memwait, loaduse;

  assign memwait = dmem_req_i & ~dhit_i;
  assign loaduse = idex_DRen_i & (idex_Rt_i != 5'd0) &
                   ((idex_Rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_Rt_i == ifid_rt_i)));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    idex_noop  = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    if (!nRST) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state)
        HALTED: halted = 1'b1;
        DRAIN: begin
          // Halt stays parked in EX/MEM; only MEM/WB advances, and only on a data hit.
          memwb_en = ~memwait;
          if (!memwait) begin
            if (cnt == 2'd0) state_n = HALTED;
            else             cnt_n   = cnt - 2'd1;
          end
        end
        default: begin
          if (exmem_halt_i) begin
            memwb_en = ~memwait;
            state_n  = DRAIN;
            cnt_n    = DRAIN_LOAD;
          end else if (memwait) begin
            if (state == RUN) state_n = MEMWAIT;
          end else if (state == FLUSH) begin
            // PC already holds the target; keep squashing until the count runs out.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (cnt <= 2'd1) begin
              state_n = RUN;
              cnt_n   = 2'd0;
            end else begin
              cnt_n = cnt - 2'd1;
            end
          end else if (branch_taken_i) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              cnt_n   = FLUSH_LOAD;
            end else begin
              state_n = RUN;
            end
          end else if (loaduse) begin
            idex_noop = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            state_n   = RUN;
          end else begin
            pc_en     = ihit_i;
            ifid_en   = ihit_i;
            idex_noop = ~ihit_i;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            memwb_en  = 1'b1;
            state_n   = RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
      flush_cnt  <= 32'd0;
    end else if (state != HALTED) begin
      stall_cnt  <= stall_cnt  + 32'(memwait);
      bubble_cnt <= bubble_cnt + 32'(idex_noop);
      flush_cnt  <= flush_cnt  + 32'(idex_flush);
    end
  end
`endif

endmodule
